// File: rtl/unidade_controle.sv
// Multicycle control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with retirement counter.
// Optional conditional-branch support is enabled by defining BRANCH_EN.
`timescale 1ns/1ps

// state     | meaning
// IDLE      | waiting for start
// FETCH     | IR load pulse
// DECODE    | fields valid on opcode/funct3/funct7, latched on exit
// EXECUTE   | ULA operation driven from latched fields
// MEMORY    | load access, or store write + retire
// WRITEBACK | register-file write + retire
// HALT      | stopped until reset (ECALL or illegal encoding)
module unidade_controle (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        flag,
  output logic        ir_enable,
  output logic        pc_enable,
  output logic        reg_we,
  output logic        mem_we,
  output logic        sinalMux1,
  output logic        sinalMux4,
  output logic [1:0]  sinalMux2,
  output logic [3:0]  alu_ctrl,
  output logic        pc_sel,
  output logic        done,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT
  } state_t;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ADDI, I_LOAD, I_STORE, I_JAL, I_BRANCH, I_ECALL, I_ILLEGAL
  } instr_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t      state, state_n;
  instr_t      cls_in, cls_q;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic        illegal_q;

  function automatic instr_t classify(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    instr_t c;
    c = I_ILLEGAL;
    case (op)
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'b0000000)      c = I_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) c = I_SUB;
      end
      7'b0010011: if (f3 == 3'b000) c = I_ADDI;
      7'b0000011: c = I_LOAD;
      7'b0100011: c = I_STORE;
      7'b1101111: c = I_JAL;
      7'b1110011: c = I_ECALL;
`ifdef BRANCH_EN
      7'b1100011: c = I_BRANCH;
`endif
      default: c = I_ILLEGAL;
    endcase
    return c;
  endfunction

  always_comb begin
    cls_in = classify(opcode, funct3, funct7);
    cls_q  = classify(op_q, f3_q, f7_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 7'd0;
      f3_q      <= 3'd0;
      f7_q      <= 7'd0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) begin
        op_q      <= opcode;
        f3_q      <= funct3;
        f7_q      <= funct7;
        illegal_q <= (cls_in == I_ILLEGAL);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = FETCH;
      FETCH:     state_n = DECODE;
      DECODE: begin
        if (cls_in == I_ECALL || cls_in == I_ILLEGAL) state_n = HALT;
        else                                          state_n = EXECUTE;
      end
      EXECUTE: begin
        if (cls_q == I_LOAD || cls_q == I_STORE) state_n = MEMORY;
        else if (cls_q == I_BRANCH)              state_n = FETCH;
        else                                     state_n = WRITEBACK;
      end
      MEMORY: begin
        if (cls_q == I_STORE) state_n = FETCH;
        else                  state_n = WRITEBACK;
      end
      WRITEBACK: state_n = FETCH;
      HALT:      state_n = HALT;
      default:   state_n = IDLE;
    endcase
  end

  // Reset masks every output combinationally so no enable escapes on the reset edge.
  always_comb begin
    ir_enable = 1'b0;
    pc_enable = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    sinalMux1 = 1'b0;
    sinalMux4 = 1'b0;
    sinalMux2 = 2'b00;
    alu_ctrl  = ALU_ADD;
    pc_sel    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      if (state == EXECUTE || state == MEMORY || state == WRITEBACK) begin
        case (cls_q)
          I_ADD:    begin sinalMux1 = 1'b1; sinalMux4 = 1'b1; sinalMux2 = 2'b01; end
          I_SUB:    begin alu_ctrl = ALU_SUB; sinalMux1 = 1'b1; sinalMux4 = 1'b1;
                          sinalMux2 = 2'b01; end
          I_ADDI:   begin sinalMux4 = 1'b1; sinalMux2 = 2'b01; end
          I_LOAD:   sinalMux4 = 1'b1;
          I_STORE:  sinalMux4 = 1'b1;
          I_JAL:    begin sinalMux2 = 2'b10; pc_sel = 1'b1; end
          I_BRANCH: begin alu_ctrl = ALU_SUB; sinalMux1 = 1'b1; sinalMux4 = 1'b1;
                          pc_sel = flag; end
          default:  ;
        endcase
      end
      case (state)
        FETCH:     ir_enable = 1'b1;
        EXECUTE:   if (cls_q == I_BRANCH) pc_enable = 1'b1;
        MEMORY:    if (cls_q == I_STORE) begin mem_we = 1'b1; pc_enable = 1'b1; end
        WRITEBACK: begin reg_we = 1'b1; pc_enable = 1'b1; end
        HALT:      begin done = 1'b1; illegal = illegal_q; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      instr_count <= 16'd0;
    else if (pc_enable && instr_count != 16'hFFFF)
      instr_count <= instr_count + 16'd1;
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized self-checking bench for unidade_controle: per-cycle expected output
// vectors are built from the instruction kind and compared every cycle.
`timescale 1ns/1ps

module tb_unidade_controle;

  logic        clock = 1'b0;
  logic        reset, start, flag;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        ir_enable, pc_enable, reg_we, mem_we, sinalMux1, sinalMux4, pc_sel, done, illegal;
  logic [1:0]  sinalMux2;
  logic [3:0]  alu_ctrl;
  logic [15:0] instr_count;

  unidade_controle dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .flag(flag), .ir_enable(ir_enable), .pc_enable(pc_enable),
    .reg_we(reg_we), .mem_we(mem_we), .sinalMux1(sinalMux1), .sinalMux4(sinalMux4),
    .sinalMux2(sinalMux2), .alu_ctrl(alu_ctrl), .pc_sel(pc_sel), .done(done),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

`ifdef BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LOAD = 3, K_STORE = 4, K_JAL = 5,
                 K_BRANCH = 6, K_ECALL = 7, K_ILL = 8, K_ILL_F7 = 9;

  // vector layout: ir pc rw mw m1 m4 m2[1:0] alu[3:0] pc_sel done illegal
  localparam logic [14:0] E_IR = 15'h4000, E_PC = 15'h2000, E_RW = 15'h1000, E_MW = 15'h0800;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;
  logic [14:0] exp_q[$];
  logic [14:0] dut_vec;

  assign dut_vec = {ir_enable, pc_enable, reg_we, mem_we, sinalMux1, sinalMux4,
                    sinalMux2, alu_ctrl, pc_sel, done, illegal};

  function automatic logic [14:0] pack(input bit m1, input bit m4, input bit [1:0] m2,
                                       input bit [3:0] alu, input bit pcs, input bit dn,
                                       input bit il);
    return {4'b0000, m1, m4, m2, alu, pcs, dn, il};
  endfunction

  localparam logic [14:0] IDLE_V = {4'b0000, 1'b0, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic encode(input int k, output logic [6:0] op, output logic [2:0] f3,
                        output logic [6:0] f7);
    logic [6:0] spare[4];
    spare[0] = 7'b0010111; spare[1] = 7'b0110111; spare[2] = 7'b1100111; spare[3] = 7'b0000000;
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    op = 7'b0110011;
    case (k)
      K_ADD:    begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
      K_SUB:    begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      K_ADDI:   begin op = 7'b0010011; f3 = 3'b000; end
      K_LOAD:   op = 7'b0000011;
      K_STORE:  op = 7'b0100011;
      K_JAL:    op = 7'b1101111;
      K_BRANCH: op = 7'b1100011;
      K_ECALL:  op = 7'b1110011;
      K_ILL_F7: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000001; end
      default: begin
        case ($urandom_range(0, 3))
          0: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000001; end
          1: begin op = 7'b0110011; f3 = 3'($urandom_range(1, 7)); end
          2: begin op = 7'b0010011; f3 = 3'($urandom_range(1, 7)); end
          default: op = spare[$urandom_range(0, 3)];
        endcase
      end
    endcase
  endtask

  function automatic bit halts(input int k);
    return (k == K_ECALL || k == K_ILL || k == K_ILL_F7 || (k == K_BRANCH && !BR));
  endfunction

  task automatic expect_seq(input int k, input bit fl);
    logic [14:0] c;
    exp_q.delete();
    exp_q.push_back(IDLE_V | E_IR);
    exp_q.push_back(IDLE_V);
    if (halts(k)) begin
      exp_q.push_back(pack(0, 0, 2'b00, 4'b0010, 0, 1, (k != K_ECALL)));
      return;
    end
    case (k)
      K_ADD:   c = pack(1, 1, 2'b01, 4'b0010, 0, 0, 0);
      K_SUB:   c = pack(1, 1, 2'b01, 4'b0110, 0, 0, 0);
      K_ADDI:  c = pack(0, 1, 2'b01, 4'b0010, 0, 0, 0);
      K_LOAD:  c = pack(0, 1, 2'b00, 4'b0010, 0, 0, 0);
      K_STORE: c = pack(0, 1, 2'b00, 4'b0010, 0, 0, 0);
      K_JAL:   c = pack(0, 0, 2'b10, 4'b0010, 1, 0, 0);
      default: c = pack(1, 1, 2'b00, 4'b0110, fl, 0, 0);
    endcase
    exp_q.push_back(k == K_BRANCH ? (c | E_PC) : c);
    if (k == K_LOAD)  exp_q.push_back(c);
    if (k == K_STORE) exp_q.push_back(c | E_MW | E_PC);
    if (k != K_STORE && k != K_BRANCH) exp_q.push_back(c | E_RW | E_PC);
  endtask

  // Entered in the FETCH cycle; leaves in the next FETCH (or in HALT).
  // abort_at >= 0 asserts reset during that cycle of the instruction.
  task automatic run_instr(input int k, input bit fl, input string name, input int abort_at);
    logic [6:0] op, f7;
    logic [2:0] f3;
    encode(k, op, f3, f7);
    opcode = op; funct3 = f3; funct7 = f7;
    flag = (k == K_BRANCH) ? fl : 1'($urandom);
    check_eq({name, ".cnt0"}, 32'(instr_count), 32'(exp_count));
    expect_seq(k, fl);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 2) begin
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        if (k != K_BRANCH) flag = 1'($urandom);
      end
      check_eq($sformatf("%s.c%0d", name, i), 32'(dut_vec), 32'(exp_q[i]));
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check_eq({name, ".rst_mask"}, 32'(dut_vec), 32'(IDLE_V));
        step();
        reset = 1'b0;
        exp_count = 0;
        check_eq({name, ".rst_state"}, 32'(dut_vec), 32'(IDLE_V));
        check_eq({name, ".rst_cnt"}, 32'(instr_count), 32'(exp_count));
        return;
      end
      step();
    end
    if (!halts(k) && exp_count < 65535) exp_count++;
    if (!halts(k)) check_eq({name, ".cnt1"}, 32'(instr_count), 32'(exp_count));
  endtask

  // Reset one cycle, then release it together with start: next cycle must be FETCH.
  task automatic restart();
    reset = 1'b1;
    step();
    exp_count = 0;
    check_eq("restart.vec", 32'(dut_vec), 32'(IDLE_V));
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; flag = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    step(); step();
    check_eq("reset.vec", 32'(dut_vec), 32'(IDLE_V));
    check_eq("reset.cnt", 32'(instr_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("idle.hold", 32'(dut_vec), 32'(IDLE_V));
    end
    start = 1'b1;
    step();
    start = 1'b0;

    run_instr(K_ADD,   0, "add",   -1);
    run_instr(K_SUB,   0, "sub",   -1);
    run_instr(K_STORE, 0, "store", -1);
    run_instr(K_LOAD,  0, "load",  -1);
    run_instr(K_JAL,   0, "jal",   -1);
    run_instr(K_ADDI,  0, "addi",  -1);

    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, BR ? K_BRANCH : K_JAL);
      run_instr(k, 1'($urandom), $sformatf("rnd%0d_k%0d", n, k), -1);
    end

    run_instr(K_ILL_F7, 0, "ill_f7", -1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("halt.ignore_start", 32'(dut_vec), 32'(pack(0, 0, 2'b00, 4'b0010, 0, 1, 1)));
      check_eq("halt.cnt", 32'(instr_count), 32'(exp_count));
      step();
    end
    start = 1'b0;

    restart();
    run_instr(K_ADD,   0, "pre_ecall", -1);
    run_instr(K_ECALL, 0, "ecall",     -1);
    check_eq("ecall.hold", 32'(dut_vec), 32'(pack(0, 0, 2'b00, 4'b0010, 0, 1, 0)));

    for (int n = 0; n < 6; n++) begin
      restart();
      run_instr(K_ILL, 0, $sformatf("ill%0d", n), -1);
    end

    restart();
    run_instr(K_ADD,   0, "pre_abort", -1);
    run_instr(K_STORE, 0, "abort_store", 3);
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(K_LOAD, 0, "post_abort", -1);

    restart();
    run_instr(K_BRANCH, 1, "branch_t", -1);
    if (BR) begin
      run_instr(K_BRANCH, 0, "branch_n", -1);
      run_instr(K_ADD,    0, "post_br",  -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock, all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: leaves IDLE when sampled high.
REQ-004 SHALL have ports opcode[6:0], funct3[2:0] and funct7[6:0], inputs: fields taken from the IR output.
REQ-005 SHALL have port flag, input, 1 bit: branch-taken result from the ULA.
REQ-006 SHALL have ports ir_enable, pc_enable, reg_we and mem_we, outputs, 1 bit each: IR load, PC load, register-file write and memory write.
REQ-007 SHALL have ports sinalMux1 and sinalMux4, outputs, 1 bit each: ULA operand B (0=imm, 1=doutB) and ULA operand A (0=PC, 1=doutA).
REQ-008 SHALL have port sinalMux2, output, 2 bits: writeback select (00=mem dout, 01=ULA soma, 10=PC+4, 11=PC+imm).
REQ-009 SHALL have port alu_ctrl, output, 4 bits: ULA operation (0010=ADD, 0110=SUB).
REQ-010 SHALL have port pc_sel, output, 1 bit: next-PC select (0=PC+4, 1=PC+imm).
REQ-011 SHALL have ports done and illegal, outputs, 1 bit each: halted, and halted on an illegal instruction.
REQ-012 SHALL have port instr_count, output, 16 bits: retired-instruction count.

Function
REQ-013 SHALL implement a single FSM with states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and HALT.
REQ-014 SHALL drive all outputs as functions of the registered state and of instruction fields latched at the end of DECODE; no output may depend combinationally on opcode, funct3 or funct7 outside DECODE.
REQ-015 SHALL move IDLE->FETCH on the edge where start=1, and SHALL otherwise hold IDLE.
REQ-016 SHALL assert ir_enable for exactly one cycle in FETCH, then go to DECODE.
REQ-017 SHALL, in DECODE, latch opcode, funct3 and funct7, then transition as follows.
- To HALT with illegal=0 on opcode 1110011.
- To HALT with illegal=1 on an unsupported encoding.
- Otherwise to EXECUTE.
REQ-018 SHALL support these encodings, each with fixed control values:
- ADD: 0110011/000/0000000 -> alu 0010, Mux1=1, Mux4=1, Mux2=01.
- SUB: 0110011/000/0100000 -> alu 0110, Mux1=1, Mux4=1, Mux2=01.
- ADDI: 0010011/000 -> alu 0010, Mux1=0, Mux4=1, Mux2=01.
- LOAD: 0000011 -> alu 0010, Mux1=0, Mux4=1, Mux2=00.
- STORE: 0100011 -> alu 0010, Mux1=0, Mux4=1.
- JAL: 1101111 -> Mux2=10, pc_sel=1.
REQ-019 SHALL, in EXECUTE, go to MEMORY for LOAD and STORE and to WRITEBACK for all other encodings.
REQ-020 SHALL, in MEMORY for STORE, assert mem_we and pc_enable for exactly one cycle, then go to FETCH.
REQ-021 SHALL, in MEMORY for LOAD, go to WRITEBACK.
REQ-022 SHALL, in WRITEBACK, assert reg_we and pc_enable for exactly one cycle, then go to FETCH.
REQ-023 SHALL hold alu_ctrl, Mux1, Mux2 and Mux4 stable from EXECUTE through the final cycle of the instruction.
REQ-024 SHALL treat every pc_enable pulse as a retirement and increment instr_count by 1, saturating at 16'hFFFF.
REQ-025 SHALL hold HALT with done=1 until reset; start SHALL be ignored in HALT.
REQ-026 SHALL, outside the states named above, hold all enables at 0, pc_sel at 0, alu_ctrl at 0010 and Mux1, Mux2 and Mux4 at 0.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, force the following, overriding any in-flight instruction and any enable that would otherwise be asserted that cycle:
- state IDLE;
- done=0, illegal=0, instr_count=0;
- all enables 0, pc_sel=0, alu_ctrl=0010, all mux selects 0.
REQ-028 SHALL, in the cycle after reset is released, treat start=1 as a normal IDLE->FETCH request.

Configuration
REQ-029 SHALL, with BRANCH_EN defined, decode opcode 1100011 as a branch.
- EXECUTE outputs: alu 0110, Mux1=1, Mux4=1, pc_sel=flag, pc_enable=1 for one cycle.
- Then go directly to FETCH with no writeback.
REQ-030 SHALL, without BRANCH_EN, treat opcode 1100011 as illegal (HALT, illegal=1).

Verification
REQ-031 SHALL verify reset then start: start=1 for 1 cycle -> ir_enable high in cycle 1; ADD (funct7=0) retires with reg_we and pc_enable high in cycle 4; instr_count=1.
REQ-032 SHALL verify SUB then STORE: SUB -> alu_ctrl=0110 in EXECUTE; STORE -> mem_we high for exactly 1 cycle in MEMORY and reg_we never high; instr_count=2.
REQ-033 SHALL verify LOAD: sinalMux2=00 in WRITEBACK; the instruction takes 5 cycles FETCH->WRITEBACK.
REQ-034 SHALL verify illegal decode: opcode 0110011 with funct7=0000001 -> HALT, done=1, illegal=1; a later start=1 causes no state change.
REQ-035 SHALL verify reset mid-operation: reset=1 during MEMORY of a STORE -> mem_we=0 that cycle, state IDLE, instr_count=0.
REQ-036 SHALL verify branches with BRANCH_EN defined: flag=1 -> pc_sel=1; flag=0 -> pc_sel=0. Without BRANCH_EN: opcode 1100011 -> illegal=1.
